// File: rtl/sys_cmd_decoder.sv
// AA/BB/CC/DD command-frame decoder: turns validated UART RX bytes into single-cycle
// register-file write/read and ALU-execute strobes, with abort, timeout and busy-drop handling.
module sys_cmd_decoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  input  logic                  RSP_ACK,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic                  ILL_CMD,
  output logic                  ERR_ABORT,
  output logic [7:0]            DROP_CNT
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ADDR  = 3'd1;
  localparam logic [2:0] S_WR_DATA  = 3'd2;
  localparam logic [2:0] S_RD_ADDR  = 3'd3;
  localparam logic [2:0] S_OP_A     = 3'd4;
  localparam logic [2:0] S_OP_B     = 3'd5;
  localparam logic [2:0] S_ALU_FUNC = 3'd6;
  localparam logic [2:0] S_WAIT_RSP = 3'd7;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hDD);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]            state_p1;
  logic [TMO_W-1:0]      tmo_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic                  wr_en_p1, rd_en_p1, alu_en_p1, gate_p1, ill_p1, abort_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic [FUN_WIDTH-1:0]  fun_p1;
  logic [7:0]            drop_p1;

  logic [2:0]            state_p0;
  logic [TMO_W-1:0]      tmo_p0;
  logic [ADDR_WIDTH-1:0] wr_addr_p0;
  logic                  wr_en_p0, rd_en_p0, alu_en_p0, gate_p0, ill_p0, abort_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [FUN_WIDTH-1:0]  fun_p0;
  logic [7:0]            drop_p0;
  logic                  byte_ok_p0;

  // Stage p0: decode the sampled byte against the current frame state
  always_comb begin
    state_p0   = state_p1;
    tmo_p0     = tmo_p1;
    wr_addr_p0 = wr_addr_p1;
    wr_en_p0   = 1'b0;
    rd_en_p0   = 1'b0;
    alu_en_p0  = 1'b0;
    ill_p0     = 1'b0;
    abort_p0   = 1'b0;
    gate_p0    = gate_p1;
    addr_p0    = addr_p1;
    wdata_p0   = wdata_p1;
    fun_p0     = fun_p1;
    drop_p0    = drop_p1;
    byte_ok_p0 = RX_D_VLD && !RX_ERR;

    case (state_p1)
      S_IDLE: begin
        tmo_p0 = '0;
        if (byte_ok_p0) begin
          if (RX_P_DATA == CMD_WR) begin
            state_p0 = S_WR_ADDR;
          end else if (RX_P_DATA == CMD_RD) begin
            state_p0 = S_RD_ADDR;
          end else if (RX_P_DATA == CMD_OPS) begin
            state_p0 = S_OP_A;
          end else if (RX_P_DATA == CMD_ALU) begin
            state_p0 = S_ALU_FUNC;
            gate_p0  = 1'b1;
          end else begin
            ill_p0 = 1'b1;
          end
        end
      end

      S_WAIT_RSP: begin
        tmo_p0 = '0;
        if (RX_D_VLD) drop_p0 = sat_inc(drop_p1);
        if (RSP_ACK) begin
          state_p0 = S_IDLE;
          gate_p0  = 1'b0;
        end
      end

      default: begin
        if (RX_D_VLD && RX_ERR) begin
          abort_p0 = 1'b1;
          state_p0 = S_IDLE;
          tmo_p0   = '0;
          gate_p0  = 1'b0;
        end else if (RX_D_VLD) begin
          tmo_p0 = '0;
          case (state_p1)
            S_WR_ADDR: begin
              wr_addr_p0 = RX_P_DATA[ADDR_WIDTH-1:0];
              state_p0   = S_WR_DATA;
            end
            S_WR_DATA: begin
              wr_en_p0 = 1'b1;
              addr_p0  = wr_addr_p1;
              wdata_p0 = RX_P_DATA;
              state_p0 = S_IDLE;
            end
            S_RD_ADDR: begin
              rd_en_p0 = 1'b1;
              addr_p0  = RX_P_DATA[ADDR_WIDTH-1:0];
              state_p0 = S_WAIT_RSP;
            end
            S_OP_A: begin
              wr_en_p0 = 1'b1;
              addr_p0  = '0;
              wdata_p0 = RX_P_DATA;
              state_p0 = S_OP_B;
            end
            S_OP_B: begin
              wr_en_p0 = 1'b1;
              addr_p0  = ADDR_WIDTH'(1);
              wdata_p0 = RX_P_DATA;
              state_p0 = S_ALU_FUNC;
              gate_p0  = 1'b1;
            end
            default: begin
              alu_en_p0 = 1'b1;
              fun_p0    = RX_P_DATA[FUN_WIDTH-1:0];
              state_p0  = S_WAIT_RSP;
            end
          endcase
        end else if (tmo_p1 == TMO_LAST) begin
          abort_p0 = 1'b1;
          state_p0 = S_IDLE;
          tmo_p0   = '0;
          gate_p0  = 1'b0;
        end else begin
          tmo_p0 = tmo_p1 + TMO_W'(1);
        end
      end
    endcase
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p1  <= S_IDLE;
      tmo_p1    <= '0;
      wr_en_p1  <= 1'b0;
      rd_en_p1  <= 1'b0;
      alu_en_p1 <= 1'b0;
      gate_p1   <= 1'b0;
      ill_p1    <= 1'b0;
      abort_p1  <= 1'b0;
      addr_p1   <= '0;
      wdata_p1  <= '0;
      fun_p1    <= '0;
      drop_p1   <= '0;
    end else begin
      state_p1  <= state_p0;
      tmo_p1    <= tmo_p0;
      wr_en_p1  <= wr_en_p0;
      rd_en_p1  <= rd_en_p0;
      alu_en_p1 <= alu_en_p0;
      gate_p1   <= gate_p0;
      ill_p1    <= ill_p0;
      abort_p1  <= abort_p0;
      addr_p1   <= addr_p0;
      wdata_p1  <= wdata_p0;
      fun_p1    <= fun_p0;
      drop_p1   <= drop_p0;
    end
    wr_addr_p1 <= wr_addr_p0;
  end

  assign RF_WrEn     = wr_en_p1;
  assign RF_RdEn     = rd_en_p1;
  assign RF_Address  = addr_p1;
  assign RF_WrData   = wdata_p1;
  assign ALU_EN      = alu_en_p1;
  assign ALU_FUN     = fun_p1;
  assign CLK_GATE_EN = gate_p1;
  assign ILL_CMD     = ill_p1;
  assign ERR_ABORT   = abort_p1;
  assign DROP_CNT    = drop_p1;

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Bench for sys_cmd_decoder: frame-level reference model checked every cycle,
// plus directed frames with literal expectations.
module tb_sys_cmd_decoder;
  localparam int TMO = 50;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic       RX_ERR = 1'b0;
  logic       RSP_ACK = 1'b0;
  logic       RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, ILL_CMD, ERR_ABORT;
  logic [3:0] RF_Address, ALU_FUN;
  logic [7:0] RF_WrData, DROP_CNT;

  sys_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .RSP_ACK(RSP_ACK), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .ILL_CMD(ILL_CMD), .ERR_ABORT(ERR_ABORT), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of bytes accepted so far
  logic [7:0] frame[$];
  bit         busy, started;
  int         idle, drops;
  logic       e_wr, e_rd, e_alu, e_gate, e_ill, e_abort;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wdata, fb;

  task automatic m_abort();
    e_abort = 1'b1;
    e_gate  = 1'b0;
    frame.delete();
    idle = 0;
  endtask

  task automatic m_frame_byte();
    case (frame[0])
      8'hAA: if (frame.size() == 3) begin
        fb = frame[1]; e_wr = 1'b1; e_addr = fb[3:0]; e_wdata = frame[2]; frame.delete();
      end
      8'hBB: begin
        fb = frame[1]; e_rd = 1'b1; e_addr = fb[3:0]; busy = 1; frame.delete();
      end
      8'hCC: begin
        if (frame.size() == 2) begin
          e_wr = 1'b1; e_addr = 4'd0; e_wdata = frame[1];
        end else if (frame.size() == 3) begin
          e_wr = 1'b1; e_addr = 4'd1; e_wdata = frame[2]; e_gate = 1'b1;
        end else begin
          fb = frame[3]; e_alu = 1'b1; e_fun = fb[3:0]; busy = 1; frame.delete();
        end
      end
      default: begin
        fb = frame[1]; e_alu = 1'b1; e_fun = fb[3:0]; busy = 1; frame.delete();
      end
    endcase
  endtask

  always @(posedge CLK) begin
    e_wr = 1'b0; e_rd = 1'b0; e_alu = 1'b0; e_ill = 1'b0; e_abort = 1'b0;
    if (RST) begin
      started = 1; busy = 0; idle = 0; drops = 0; frame.delete();
      e_gate = 1'b0; e_addr = 4'd0; e_wdata = 8'd0; e_fun = 4'd0;
    end else if (busy) begin
      if (RX_D_VLD && drops < 255) drops++;
      if (RSP_ACK) begin busy = 0; e_gate = 1'b0; end
    end else if (frame.size() == 0) begin
      if (RX_D_VLD && !RX_ERR) begin
        if (RX_P_DATA inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
          frame.push_back(RX_P_DATA);
          idle = 0;
          if (RX_P_DATA == 8'hDD) e_gate = 1'b1;
        end else begin
          e_ill = 1'b1;
        end
      end
    end else if (RX_D_VLD && RX_ERR) begin
      m_abort();
    end else if (RX_D_VLD) begin
      frame.push_back(RX_P_DATA);
      idle = 0;
      m_frame_byte();
    end else begin
      idle++;
      if (idle == TMO) m_abort();
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("m_wren", RF_WrEn, e_wr);
      chk("m_rden", RF_RdEn, e_rd);
      chk("m_addr", RF_Address, e_addr);
      chk("m_wdata", RF_WrData, e_wdata);
      chk("m_aluen", ALU_EN, e_alu);
      chk("m_fun", ALU_FUN, e_fun);
      chk("m_gate", CLK_GATE_EN, e_gate);
      chk("m_ill", ILL_CMD, e_ill);
      chk("m_abort", ERR_ABORT, e_abort);
      chk("m_drop", DROP_CNT, 32'(drops));
    end
  end

  task automatic send(input logic [7:0] b, input logic err, input logic ack);
    RX_P_DATA = b; RX_D_VLD = 1'b1; RX_ERR = err; RSP_ACK = ack;
    @(negedge CLK);
    RX_D_VLD = 1'b0; RX_ERR = 1'b0; RSP_ACK = 1'b0;
  endtask

  task automatic ack();
    RSP_ACK = 1'b1;
    @(negedge CLK);
    RSP_ACK = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
             ILL_CMD, ERR_ABORT, DROP_CNT}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk_all_zero("reset_outputs");
    RST = 1'b0;
    @(negedge CLK);

    send(8'hAA, 0, 0); send(8'h07, 0, 0); send(8'hAA, 0, 0);
    chk("wr_strobe", {RF_WrEn, RF_Address, RF_WrData, RF_RdEn, ALU_EN}, {1'b1, 4'h7, 8'hAA, 1'b0, 1'b0});
    repeat (2) @(negedge CLK);

    send(8'hCC, 0, 0); send(8'h07, 0, 0);
    chk("opa_write", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h0, 8'h07});
    chk("gate_before_opb", CLK_GATE_EN, 1'b0);
    send(8'h08, 0, 0);
    chk("opb_write", {RF_WrEn, RF_Address, RF_WrData, CLK_GATE_EN}, {1'b1, 4'h1, 8'h08, 1'b1});
    send(8'h00, 0, 0);
    chk("alu_exec", {ALU_EN, ALU_FUN, CLK_GATE_EN}, {1'b1, 4'h0, 1'b1});
    repeat (3) @(negedge CLK);
    chk("gate_held", CLK_GATE_EN, 1'b1);
    ack();
    chk("gate_cleared", CLK_GATE_EN, 1'b0);
    send(8'h55, 0, 0);
    chk("idle_after_ack", ILL_CMD, 1'b1);

    send(8'hBB, 0, 0); send(8'h0C, 0, 0);
    chk("rd_strobe", {RF_RdEn, RF_Address, RF_WrEn, CLK_GATE_EN}, {1'b1, 4'hC, 1'b0, 1'b0});
    send(8'hAA, 0, 0); send(8'h12, 1, 0); send(8'h34, 0, 1);
    chk("drop_cnt3", DROP_CNT, 8'd3);
    send(8'hFE, 1, 0);
    chk("err_in_idle", {ERR_ABORT, ILL_CMD}, 2'b00);

    send(8'h55, 0, 0);
    chk("ill_cmd", ILL_CMD, 1'b1);
    send(8'hDD, 0, 0);
    chk("dd_gate", CLK_GATE_EN, 1'b1);
    send(8'h0A, 0, 0);
    chk("dd_alu", {ALU_EN, ALU_FUN, RF_WrEn}, {1'b1, 4'hA, 1'b0});
    ack();

    send(8'hCC, 0, 0); send(8'h09, 0, 0);
    chk("abort_opa", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h0, 8'h09});
    send(8'h44, 1, 0);
    chk("abort_err", {ERR_ABORT, RF_WrEn, ALU_EN, CLK_GATE_EN}, 4'b1000);

    send(8'hAA, 0, 0); send(8'h03, 0, 0);
    repeat (TMO - 1) @(negedge CLK);
    chk("tmo_not_yet", ERR_ABORT, 1'b0);
    @(negedge CLK);
    chk("tmo_abort", {ERR_ABORT, RF_WrEn}, 2'b10);
    send(8'h44, 0, 0);
    chk("tmo_back_idle", {RF_WrEn, ILL_CMD}, 2'b01);

    ack();
    send(8'hCC, 0, 0); send(8'h11, 0, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk_all_zero("reset_in_opb");
    RST = 1'b0;
    send(8'hAA, 0, 0); send(8'h02, 0, 0); send(8'h43, 0, 0);
    chk("wr_after_reset", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h2, 8'h43});

    send(8'hBB, 0, 0); send(8'h01, 0, 0);
    for (int i = 0; i < 300; i++) send(8'(i), 0, 0);
    chk("drop_sat", DROP_CNT, 8'd255);
    ack();
    send(8'hAA, 0, 0); send(8'h05, 0, 0); send(8'h66, 0, 0);
    chk("wr_after_sat", {RF_WrEn, RF_Address, RF_WrData, DROP_CNT}, {1'b1, 4'h5, 8'h66, 8'hFF});

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
